pwm_multi_channel: RTL and testbench

Parametrised successor to the single-channel PWM generator: CHANNELS independent PWM outputs share one period counter. Adds a programmable prescaler, edge- or center-aligned counting, and double-buffered period/duty registers that update only at the period boundary, so outputs never glitch. Sits behind the user-project top level; register writes come from ui_in/uio_in decode, outputs drive uo_out.

---
 rtl/pwm_multi_channel.sv | 151 +++++++++++++++
 tb/tb_pwm_multi_channel.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
//   CHANNELS PWM outputs sharing one period counter. The counter runs from a
//   programmable prescaler, counts edge-aligned (0..P, wrap) or center-aligned
//   (0..P..1, repeat). Period and duty registers are double-buffered: writes
//   land in pending registers, which are copied to the active set only at a
//   period boundary (or every clock while disabled), so outputs never glitch.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   en            run enable (0 holds counter/prescaler at 0, outputs low)
//   mode          0 = edge-aligned, 1 = center-aligned
//   prescale      counter advances every prescale+1 clocks
//   period_wr/period_data         pending period write
//   duty_wr/duty_addr/duty_data   pending duty write (addr >= CHANNELS ignored)
//   pwm_out       registered PWM outputs
//   period_start  one-clock pulse when the counter returns to 0
//   counter       current counter value
module pwm_multi_channel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRE_W    = 8,
  parameter int AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [PRE_W-1:0]    prescale,
  input  logic                period_wr,
  input  logic [WIDTH-1:0]    period_data,
  input  logic                duty_wr,
  input  logic [AW-1:0]       duty_addr,
  input  logic [WIDTH-1:0]    duty_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
  output logic [WIDTH-1:0]    counter
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0]    counter_q, counter_d;
  dir_e                dir_q, dir_d;
  logic [WIDTH-1:0]    pend_period_q, pend_period_d;
  logic [WIDTH-1:0]    act_period_q, act_period_d;
  logic [WIDTH-1:0]    pend_duty_q [CHANNELS];
  logic [WIDTH-1:0]    pend_duty_d [CHANNELS];
  logic [WIDTH-1:0]    act_duty_q  [CHANNELS];
  logic [WIDTH-1:0]    act_duty_d  [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q, period_start_d;
  logic                tick;
  logic                boundary;

  always_comb begin
    presc_d        = presc_q;
    counter_d      = counter_q;
    dir_d          = dir_q;
    pend_period_d  = pend_period_q;
    pend_duty_d    = pend_duty_q;
    act_period_d   = act_period_q;
    act_duty_d     = act_duty_q;
    tick           = 1'b0;
    boundary       = 1'b0;

    if (period_wr) pend_period_d = period_data;
    // Equality decode per channel: out-of-range addresses match nothing.
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (duty_wr && (duty_addr == AW'(i))) pend_duty_d[i] = duty_data;
    end

    if (!en) begin
      presc_d      = '0;
      counter_d    = '0;
      dir_d        = DIR_UP;
      act_period_d = pend_period_q;
      act_duty_d   = pend_duty_q;
    end else begin
      // >= rather than == so a live prescale decrease cannot overrun.
      tick    = (presc_q >= prescale);
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (!mode) begin
          dir_d = DIR_UP;
          if (counter_q >= act_period_q) begin
            counter_d = '0;
            boundary  = 1'b1;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end else if (act_period_q == '0) begin
          counter_d = '0;
          dir_d     = DIR_UP;
          boundary  = 1'b1;
        end else if ((dir_q == DIR_UP) && (counter_q < act_period_q)) begin
          counter_d = counter_q + 1'b1;
        end else if (counter_q <= WIDTH'(1)) begin
          // Descending (or turning at P=1) into 0 closes the period.
          counter_d = '0;
          dir_d     = DIR_UP;
          boundary  = 1'b1;
        end else begin
          counter_d = counter_q - 1'b1;
          dir_d     = DIR_DOWN;
        end
      end
      // Active set loads the pre-write pending value on a coincident write.
      if (boundary) begin
        act_period_d = pend_period_q;
        act_duty_d   = pend_duty_q;
      end
    end

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en && (counter_q < act_duty_q[i]);
    end
    period_start_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      counter_q      <= '0;
      dir_q          <= DIR_UP;
      pend_period_q  <= '1;
      act_period_q   <= '1;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pend_duty_q[i] <= '0;
        act_duty_q[i]  <= '0;
      end
    end else begin
      presc_q        <= presc_d;
      counter_q      <= counter_d;
      dir_q          <= dir_d;
      pend_period_q  <= pend_period_d;
      act_period_q   <= act_period_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pend_duty_q[i] <= pend_duty_d[i];
        act_duty_q[i]  <= act_duty_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign counter      = counter_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel (3 channels so that duty_addr can
// address a non-existent channel). The reference model tracks the phase
// within the current period and maps it to a counter value arithmetically.
module tb_pwm_multi_channel;

  localparam int W  = 8;
  localparam int CH = 3;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic          period_wr = 1'b0;
  logic [W-1:0]  period_data = '0;
  logic          duty_wr = 1'b0;
  logic [1:0]    duty_addr = '0;
  logic [W-1:0]  duty_data = '0;
  logic [CH-1:0] pwm_out;
  logic          period_start;
  logic [W-1:0]  counter;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(CH), .PRE_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .prescale(prescale),
    .period_wr(period_wr), .period_data(period_data),
    .duty_wr(duty_wr), .duty_addr(duty_addr), .duty_data(duty_data),
    .pwm_out(pwm_out), .period_start(period_start), .counter(counter)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int            m_presc = 0;
  int            m_ph    = 0;
  int            m_P     = 255;
  int            m_pP    = 255;
  int            m_duty  [CH];
  int            m_pduty [CH];
  logic [CH-1:0] exp_pwm = '0;
  logic          exp_ps  = 1'b0;
  logic [W-1:0]  exp_cnt = '0;

  function automatic int plen(input int p, input logic md);
    if (!md) return p + 1;
    return (p == 0) ? 1 : 2 * p;
  endfunction

  function automatic int cnt_of(input int ph, input int p, input logic md);
    if (!md) return ph;
    if (p == 0) return 0;
    return (ph <= p) ? ph : 2 * p - ph;
  endfunction

  always @(posedge clk) begin
    int cnt;
    int old_pP;
    int old_pd [CH];
    cnt    = int'(exp_cnt);
    old_pP = m_pP;
    old_pd = m_pduty;
    if (rst) begin
      m_presc = 0; m_ph = 0; m_P = 255; m_pP = 255;
      for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_pduty[i] = 0; end
      exp_pwm = '0;
      exp_ps  = 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) exp_pwm[i] = en && (cnt < m_duty[i]);
      exp_ps = 1'b0;
      if (period_wr) m_pP = int'(period_data);
      if (duty_wr && int'(duty_addr) < CH) m_pduty[int'(duty_addr)] = int'(duty_data);
      if (!en) begin
        m_presc = 0; m_ph = 0; m_P = old_pP; m_duty = old_pd;
      end else if (m_presc >= int'(prescale)) begin
        m_presc = 0;
        m_ph++;
        if (m_ph >= plen(m_P, mode)) begin
          m_ph = 0; exp_ps = 1'b1; m_P = old_pP; m_duty = old_pd;
        end
      end else begin
        m_presc++;
      end
    end
    exp_cnt = W'(cnt_of(m_ph, m_P, mode));
  end

  // Program pending registers while disabled, then enable.
  task automatic cfg(input logic md, input int pre, input int p, input int d0, input int d1, input int d2);
    @(negedge clk);
    en = 1'b0; mode = md; prescale = PW'(pre);
    period_wr = 1'b1; period_data = W'(p);
    @(negedge clk);
    period_wr = 1'b0; duty_wr = 1'b1; duty_addr = 2'd0; duty_data = W'(d0);
    @(negedge clk);
    duty_addr = 2'd1; duty_data = W'(d1);
    @(negedge clk);
    duty_addr = 2'd2; duty_data = W'(d2);
    @(negedge clk);
    duty_wr = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pwm_out, period_start, counter} !== {CH'(0), 1'b0, W'(0)})
      $display("FAIL reset_state: got pwm=%b ps=%b cnt=%0d, want 0/0/0", pwm_out, period_start, counter);
    else n_pass++;
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (counter !== W'(i + 1) || pwm_out !== '0)
        $display("FAIL reset_defaults: got cnt=%0d pwm=%b, want cnt=%0d pwm=000", counter, pwm_out, i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_edge;
    int hi = 0, ps = 0;
    cfg(1'b0, 0, 9, 3, 2, 7);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if ({pwm_out, period_start, counter} !== {exp_pwm, exp_ps, exp_cnt})
        $display("FAIL edge: got pwm=%b ps=%b cnt=%0d, want pwm=%b ps=%b cnt=%0d", pwm_out, period_start, counter, exp_pwm, exp_ps, exp_cnt);
      else n_pass++;
      if (i >= 10) begin hi += int'(pwm_out[0]); ps += int'(period_start); end
    end
    n_checks++;
    if (hi != 9 || ps != 3) $display("FAIL edge_counts: got hi=%0d ps=%0d, want hi=9 ps=3", hi, ps);
    else n_pass++;
  endtask

  task automatic test_mid_write;
    int hi0 = 0, hi1 = 0;
    bit found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_checks++;
      if ({pwm_out, period_start, counter} !== {exp_pwm, exp_ps, exp_cnt})
        $display("FAIL mid_write: got pwm=%b ps=%b cnt=%0d, want pwm=%b ps=%b cnt=%0d", pwm_out, period_start, counter, exp_pwm, exp_ps, exp_cnt);
      else n_pass++;
      duty_wr = 1'b0;
      if (!found && exp_cnt == W'(4)) begin
        found = 1; duty_wr = 1'b1; duty_addr = 2'd1; duty_data = W'(5);
      end
      if (i >= 40) begin hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); end
    end
    duty_wr = 1'b0;
    n_checks++;
    if (!found || hi1 != 10 || hi0 != 6)
      $display("FAIL mid_write_counts: got found=%0d hi1=%0d hi0=%0d, want 1/10/6", found, hi1, hi0);
    else n_pass++;
  endtask

  task automatic test_center;
    int hi0 = 0, hi1 = 0, hi2 = 0, ps = 0;
    cfg(1'b1, 0, 4, 2, 0, 4);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if ({pwm_out, period_start, counter} !== {exp_pwm, exp_ps, exp_cnt})
        $display("FAIL center: got pwm=%b ps=%b cnt=%0d, want pwm=%b ps=%b cnt=%0d", pwm_out, period_start, counter, exp_pwm, exp_ps, exp_cnt);
      else n_pass++;
      if (i >= 8) begin
        hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); hi2 += int'(pwm_out[2]);
        ps += int'(period_start);
      end
    end
    n_checks++;
    if (hi0 != 12 || hi1 != 0 || hi2 != 28 || ps != 4)
      $display("FAIL center_counts: got %0d/%0d/%0d ps=%0d, want 12/0/28 ps=4", hi0, hi1, hi2, ps);
    else n_pass++;
  endtask

  task automatic test_duty_limits;
    int hi2 = 0;
    cfg(1'b0, 0, 9, 0, 10, 6);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if ({pwm_out, period_start, counter} !== {exp_pwm, exp_ps, exp_cnt})
        $display("FAIL limits: got pwm=%b ps=%b cnt=%0d, want pwm=%b ps=%b cnt=%0d", pwm_out, period_start, counter, exp_pwm, exp_ps, exp_cnt);
      else n_pass++;
      n_checks++;
      if (pwm_out[0] !== 1'b0 || pwm_out[1] !== 1'b1)
        $display("FAIL limits_const: got ch0=%b ch1=%b, want ch0=0 ch1=1", pwm_out[0], pwm_out[1]);
      else n_pass++;
      duty_wr = (i == 5);
      duty_addr = 2'd3; duty_data = W'(1);
      if (i >= 10) hi2 += int'(pwm_out[2]);
    end
    duty_wr = 1'b0;
    n_checks++;
    if (hi2 != 18) $display("FAIL limits_ch2: got hi=%0d, want 18", hi2);
    else n_pass++;
  endtask

  task automatic test_prescale;
    int hi = 0, ps = 0, chg = 0;
    logic [W-1:0] prev;
    cfg(1'b0, 3, 9, 5, 0, 0);
    prev = '0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      n_checks++;
      if ({pwm_out, period_start, counter} !== {exp_pwm, exp_ps, exp_cnt})
        $display("FAIL prescale: got pwm=%b ps=%b cnt=%0d, want pwm=%b ps=%b cnt=%0d", pwm_out, period_start, counter, exp_pwm, exp_ps, exp_cnt);
      else n_pass++;
      if (i >= 40) begin
        hi += int'(pwm_out[0]); ps += int'(period_start);
        if (counter != prev) chg++;
      end
      prev = counter;
    end
    n_checks++;
    if (hi != 40 || ps != 2 || chg != 20)
      $display("FAIL prescale_counts: got hi=%0d ps=%0d chg=%0d, want 40/2/20", hi, ps, chg);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int hi = 0;
    cfg(1'b0, 0, 9, 3, 3, 3);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if ({pwm_out, period_start, counter} !== {exp_pwm, exp_ps, exp_cnt})
        $display("FAIL reset_mid: got pwm=%b ps=%b cnt=%0d, want pwm=%b ps=%b cnt=%0d", pwm_out, period_start, counter, exp_pwm, exp_ps, exp_cnt);
      else n_pass++;
      if (i == 6) begin
        n_checks++;
        if ({pwm_out, period_start, counter} !== {CH'(0), 1'b0, W'(0)})
          $display("FAIL reset_mid_state: got pwm=%b ps=%b cnt=%0d, want 0/0/0", pwm_out, period_start, counter);
        else n_pass++;
      end
      rst = (i == 5);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n_checks++;
      if ({pwm_out, period_start, counter} !== {exp_pwm, exp_ps, exp_cnt})
        $display("FAIL reset_recover: got pwm=%b ps=%b cnt=%0d, want pwm=%b ps=%b cnt=%0d", pwm_out, period_start, counter, exp_pwm, exp_ps, exp_cnt);
      else n_pass++;
      if (i < 240) begin
        n_checks++;
        if (pwm_out !== '0) $display("FAIL reset_low: got pwm=%b at %0d, want 000", pwm_out, i);
        else n_pass++;
      end
      duty_wr = (i == 2); duty_addr = 2'd0; duty_data = W'(3);
      period_wr = (i == 3); period_data = W'(9);
      if (i >= 270) hi += int'(pwm_out[0]);
    end
    duty_wr = 1'b0; period_wr = 1'b0;
    n_checks++;
    if (hi != 9) $display("FAIL reset_recover_hi: got hi=%0d, want 9", hi);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      int p;
      p = $urandom_range(0, 12);
      cfg(1'($urandom_range(0, 1)), $urandom_range(0, 2), p,
          $urandom_range(0, p + 2), $urandom_range(0, p + 2), $urandom_range(0, p + 2));
      for (int i = 0; i < 150; i++) begin
        @(negedge clk);
        n_checks++;
        if ({pwm_out, period_start, counter} !== {exp_pwm, exp_ps, exp_cnt})
          $display("FAIL random r%0d c%0d: got pwm=%b ps=%b cnt=%0d, want pwm=%b ps=%b cnt=%0d", r, i, pwm_out, period_start, counter, exp_pwm, exp_ps, exp_cnt);
        else n_pass++;
        period_wr   = ($urandom_range(0, 15) == 0);
        period_data = W'($urandom_range(0, 12));
        duty_wr     = ($urandom_range(0, 3) == 0);
        duty_addr   = 2'($urandom_range(0, 3));
        duty_data   = W'($urandom_range(0, 14));
        en          = ($urandom_range(0, 39) != 0);
      end
      period_wr = 1'b0; duty_wr = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_pduty[i] = 0; end
    test_reset;
    test_edge;
    test_mid_write;
    test_center;
    test_duty_limits;
    test_prescale;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
